// File: rtl/audio_clk_gen_tdm.sv
// Audio master-clock divider: BCK, LRCK/FSYNC, slot index and frame strobe.
// Rate changes land on frame boundaries and are followed by a mute window.
module audio_clk_gen_tdm #(
    parameter int MCK_FS_BASE = 512,
    parameter int SLOTS       = 2,
    parameter int SLOT_BITS   = 32,
    parameter int MUTE_FRAMES = 4,
    parameter int CW          = $clog2(MCK_FS_BASE)
) (
    input  logic                     MCK_in,
    input  logic                     RST_n,
    input  logic [1:0]               RATE_SEL,
    input  logic                     TDM_MODE,
    output logic                     MCK_out,
    output logic                     BCK_out,
    output logic                     LRCK_out,
    output logic [$clog2(SLOTS)-1:0] SLOT_IDX,
    output logic                     FRAME_STB,
    output logic                     MUTE_out,
    output logic                     RATE_ERR
);

    localparam int SW = $clog2(SLOTS);
    localparam int FB = $clog2(SLOTS * SLOT_BITS);
    localparam int BB = $clog2(SLOT_BITS);
    localparam int MW = $clog2(MUTE_FRAMES + 1);

    // L = 2^(CW-r), P = 2^(CW-r-FB); valid iff P >= 2
    function automatic logic rate_ok(input logic [1:0] r);
        return (r != 2'd3) && (CW - int'(r) - FB >= 1);
    endfunction

    logic [CW-1:0] cnt;
    logic [1:0]    rate;
    logic          pend_vld;
    logic [1:0]    pend_rate;
    logic          tdm;
    logic [MW-1:0] mute_cnt;

    logic          last;
    logic          apply;
    logic [1:0]    rate_n;
    logic          tdm_n;
    logic [CW-1:0] cnt_n;
    logic [MW-1:0] mute_n;
    int            lp;
    logic [CW-1:0] sh_bck;
    logic [CW-1:0] sh_slot;
    logic          bck_n;
    logic          lrck_n;
    logic [SW-1:0] slot_n;
    logic          stb_n;

    assign MCK_out = MCK_in;

    always_comb begin
        last    = (cnt == ({CW{1'b1}} >> rate));
        apply   = last && pend_vld;
        rate_n  = apply ? pend_rate : rate;
        tdm_n   = last ? TDM_MODE : tdm;
        cnt_n   = last ? '0 : cnt + 1'b1;
        lp      = CW - int'(rate_n) - FB;
        sh_bck  = cnt_n >> (lp - 1);
        sh_slot = cnt_n >> (lp + BB);
        bck_n   = sh_bck[0];
        slot_n  = sh_slot[SW-1:0];
        stb_n   = (cnt_n == ({CW{1'b1}} >> rate_n));
        if (tdm_n)
            lrck_n = ((cnt_n >> lp) == '0);
        else
            lrck_n = (cnt_n >= ({1'b1, {(CW-1){1'b0}}} >> rate_n));
        if (apply)
            mute_n = MW'(MUTE_FRAMES);
        else if (last && mute_cnt != '0)
            mute_n = mute_cnt - 1'b1;
        else
            mute_n = mute_cnt;
    end

    always_ff @(posedge MCK_in) begin
        if (!RST_n) begin
            cnt       <= '0;
            rate      <= rate_ok(RATE_SEL) ? RATE_SEL : 2'd0;
            pend_vld  <= 1'b0;
            pend_rate <= 2'd0;
            tdm       <= TDM_MODE;
            mute_cnt  <= MW'(MUTE_FRAMES);
            BCK_out   <= 1'b0;
            LRCK_out  <= 1'b0;
            SLOT_IDX  <= '0;
            FRAME_STB <= 1'b0;
            MUTE_out  <= 1'b1;
            RATE_ERR  <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            rate      <= rate_n;
            tdm       <= tdm_n;
            mute_cnt  <= mute_n;
            BCK_out   <= bck_n;
            LRCK_out  <= lrck_n;
            SLOT_IDX  <= slot_n;
            FRAME_STB <= stb_n;
            MUTE_out  <= (mute_n != '0);
            // requests compare against the rate in force after this edge
            if (rate_ok(RATE_SEL)) begin
                pend_vld  <= (RATE_SEL != rate_n);
                pend_rate <= RATE_SEL;
            end else begin
                RATE_ERR <= 1'b1;
                if (apply)
                    pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_clk_gen_tdm.sv
// Randomized bench: two configurations (I2S stereo, 8-slot TDM) against
// an arithmetic frame-position model.
module tb_audio_clk_gen_tdm;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel [2];
    logic       mode [2];

    logic       mck_a, bck_a, lrck_a, stb_a, mute_a, err_a;
    logic [0:0] slot_a;
    logic       mck_b, bck_b, lrck_b, stb_b, mute_b, err_b;
    logic [2:0] slot_b;

    int checks = 0;
    int failures = 0;

    audio_clk_gen_tdm #(
        .MCK_FS_BASE(512), .SLOTS(2), .SLOT_BITS(32), .MUTE_FRAMES(4)
    ) dut_a (
        .MCK_in(clk), .RST_n(rst_n), .RATE_SEL(sel[0]), .TDM_MODE(mode[0]),
        .MCK_out(mck_a), .BCK_out(bck_a), .LRCK_out(lrck_a),
        .SLOT_IDX(slot_a), .FRAME_STB(stb_a), .MUTE_out(mute_a),
        .RATE_ERR(err_a)
    );

    audio_clk_gen_tdm #(
        .MCK_FS_BASE(512), .SLOTS(8), .SLOT_BITS(32), .MUTE_FRAMES(2)
    ) dut_b (
        .MCK_in(clk), .RST_n(rst_n), .RATE_SEL(sel[1]), .TDM_MODE(mode[1]),
        .MCK_out(mck_b), .BCK_out(bck_b), .LRCK_out(lrck_b),
        .SLOT_IDX(slot_b), .FRAME_STB(stb_b), .MUTE_out(mute_b),
        .RATE_ERR(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // model configuration
    int base [2] = '{512, 512};
    int nsl  [2] = '{2, 8};
    int nbit [2] = '{32, 32};
    int mfr  [2] = '{4, 2};

    // model state: position in frame, rate, pending (-1 none), etc.
    int pos [2], rate [2], pend [2], tdm [2], err [2], mleft [2], rstc [2];

    function automatic int flen(int i, int r);
        return base[i] >> r;
    endfunction

    function automatic int bper(int i, int r);
        return flen(i, r) / (nsl[i] * nbit[i]);
    endfunction

    function automatic bit valid(int i, int r);
        return r != 3 && bper(i, r) >= 2;
    endfunction

    task automatic model_step(input int i, input bit rst, input int s,
                              input int m);
        bit wrap;
        if (rst) begin
            pos[i] = 0;
            rate[i] = valid(i, s) ? s : 0;
            pend[i] = -1;
            tdm[i] = m;
            err[i] = 0;
            mleft[i] = mfr[i];
            rstc[i] = 1;
            return;
        end
        rstc[i] = 0;
        wrap = (pos[i] == flen(i, rate[i]) - 1);
        if (wrap) begin
            if (pend[i] >= 0) begin
                mleft[i] = mfr[i];
                rate[i] = pend[i];
                pend[i] = -1;
            end else if (mleft[i] > 0) begin
                mleft[i]--;
            end
            pos[i] = 0;
            tdm[i] = m;
        end else begin
            pos[i]++;
        end
        if (!valid(i, s)) err[i] = 1;
        else if (s != rate[i]) pend[i] = s;
        else pend[i] = -1;
    endtask

    task automatic compare(input int i, input int mck, input int bck,
                           input int lrck, input int slot, input int stb,
                           input int mute, input int er);
        int l, p, eb, el, es, ef;
        string n;
        n = (i == 0) ? "a" : "b";
        l = flen(i, rate[i]);
        p = bper(i, rate[i]);
        if (rstc[i] != 0) begin
            eb = 0; el = 0; es = 0; ef = 0;
        end else begin
            eb = (pos[i] % p) >= p / 2;
            el = tdm[i] != 0 ? (pos[i] < p) : (pos[i] >= l / 2);
            es = pos[i] / (p * nbit[i]);
            ef = (pos[i] == l - 1);
        end
        check({n, ".mck"}, mck, 1);
        check({n, ".bck"}, bck, eb);
        check({n, ".lrck"}, lrck, el);
        check({n, ".slot"}, slot, es);
        check({n, ".stb"}, stb, ef);
        check({n, ".mute"}, mute, mleft[i] != 0);
        check({n, ".err"}, er, err[i]);
    endtask

    int glitch [2] = '{0, 0};
    logic [1:0] hold [2];

    initial begin
        rst_n = 1'b0;
        sel[0] = 2'd0; sel[1] = 2'd0;
        mode[0] = 1'b0; mode[1] = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (c >= 3) rst_n = 1'b1;
            if (c > 2600) begin
                if ($urandom_range(0, 3999) == 0) rst_n = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    int r;
                    r = $urandom_range(0, 999);
                    if (glitch[i] > 0) begin
                        glitch[i]--;
                        if (glitch[i] == 0) sel[i] = hold[i];
                    end else if (r < 2) begin
                        sel[i] = ($urandom_range(0, 19) == 0) ? 2'd3
                               : 2'($urandom_range(0, 2));
                    end else if (r < 4) begin
                        hold[i] = sel[i];
                        sel[i] = 2'($urandom_range(0, 2));
                        glitch[i] = $urandom_range(1, 60);
                    end
                    if ($urandom_range(0, 599) == 0) mode[i] = ~mode[i];
                    if (i == 1 && sel[i] != 2'd0 && $urandom_range(0, 1) == 1)
                        sel[i] = 2'd0;
                end
            end
            @(posedge clk);
            #1;
            model_step(0, !rst_n, int'(sel[0]), int'(mode[0]));
            model_step(1, !rst_n, int'(sel[1]), int'(mode[1]));
            compare(0, mck_a, bck_a, lrck_a, int'(slot_a), stb_a, mute_a, err_a);
            compare(1, mck_b, bck_b, lrck_b, int'(slot_b), stb_b, mute_b, err_b);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
